// File: rtl/bcd_conv_arbiter_if.sv
// Request/result bus between value producers and the shared BCD converter.
//   req       : per-requester conversion request (level)
//   bin_in    : packed operands, requester k at [k*W +: W]
//   ack       : one-hot, one-cycle grant pulse (operand captured)
//   busy      : arbiter is not idle
//   bcd_valid : one-cycle pulse, bcd_out/bcd_id valid
//   bcd_out   : BCD result {..., hundreds, tens, ones}
//   bcd_id    : requester that owns bcd_out
// master = requester side, slave = arbiter side.
interface bcd_conv_arbiter_if #(
  parameter int W = 14,
  parameter int N = 4
);
  localparam int B  = W + (W - 4) / 3 + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] bin_in;
  logic [N-1:0]   ack;
  logic           busy;
  logic           bcd_valid;
  logic [B-1:0]   bcd_out;
  logic [IW-1:0]  bcd_id;

  modport master (
    output req, bin_in,
    input  ack, busy, bcd_valid, bcd_out, bcd_id
  );

  modport slave (
    input  req, bin_in,
    output ack, busy, bcd_valid, bcd_out, bcd_id
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one combinational double-dabble binary-to-BCD
// converter among N requesters. The granted operand is registered and held for
// SETTLE cycles (multicycle path through the converter), then the result is
// registered and announced with a one-cycle bcd_valid tagged by bcd_id.
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : bcd_conv_arbiter_if slave (req/bin_in in; ack/busy/bcd_* out)
// The interface instance must use the same W and N as this module.
module bcd_conv_arbiter #(
  parameter int W      = 14,
  parameter int N      = 4,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  bcd_conv_arbiter_if.slave  bus
);

  localparam int B  = W + (W - 4) / 3 + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [W-1:0]  op_q, op_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [B-1:0]  out_q, out_d;
  logic [IW-1:0] oid_q, oid_d;

  logic [B-1:0]  conv;
  logic          sel_found;
  logic [IW-1:0] sel_idx;

  // Combinational double dabble: the shift-and-add-3 steps are unrolled into
  // fixed nibble positions; field ending at bit W-i+4j is corrected in step i.
  always_comb begin
    conv = '0;
    conv[W-1:0] = op_q;
    for (int unsigned i = 0; i <= unsigned'(W - 4); i++) begin
      for (int unsigned j = 0; j <= i / 3; j++) begin
        if (conv[W - i + 4 * j -: 4] > 4'd4)
          conv[W - i + 4 * j -: 4] = conv[W - i + 4 * j -: 4] + 4'd3;
      end
    end
  end

  // Round-robin search starting at ptr_q, wrapping modulo N.
  always_comb begin
    int unsigned p;
    p         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned o = 0; o < unsigned'(N); o++) begin
      p = 32'(ptr_q) + o;
      if (p >= unsigned'(N)) p = p - unsigned'(N);
      if (!sel_found && bus.req[p]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(p);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    valid_d = 1'b0;
    out_d   = out_q;
    oid_d   = oid_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          op_d    = bus.bin_in[int'(sel_idx) * W +: W];
          id_d    = sel_idx;
          ack_d   = N'(1) << sel_idx;
          cnt_d   = 4'(SETTLE - 1);
          ptr_d   = (int'(sel_idx) == N - 1) ? '0 : sel_idx + IW'(1);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          out_d   = conv;
          oid_d   = id_q;
          valid_d = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // busy is registered from the next state so it tracks state_q exactly.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
      oid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      oid_q   <= oid_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.bcd_valid = valid_q;
  assign bus.bcd_out   = out_q;
  assign bus.bcd_id    = oid_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter (W=14, N=4, SETTLE=2): directed
// scenarios plus random traffic, compared each cycle with a transaction-level
// reference model (decimal-digit BCD, scan-based round robin, cycle stamps).
module tb_bcd_conv_arbiter;
  localparam int W      = 14;
  localparam int N      = 4;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_conv_arbiter_if #(.W(W), .N(N)) bus ();
  bcd_conv_arbiter #(.W(W), .N(N), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] bin [N];
  always_comb begin
    for (int k = 0; k < N; k++) bus.bin_in[k*W +: W] = bin[k];
  end

  int cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state.
  int          m_ptr = 0, m_free = 0, m_bend = 0, m_due = 0, m_id = 0;
  bit          m_pend = 0;
  logic [31:0] m_val = '0, m_last_out = '0;
  int          m_last_id = 0;

  // Observation logs for the directed scenarios.
  int          ack_log[$];
  int          valid_cyc[$];
  int          id_log[$];
  logic [31:0] out_log[$];

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic step();
    logic [N-1:0] r;
    logic         rs;
    logic [W-1:0] b [N];
    logic [N-1:0] e_ack;
    bit           e_valid, e_busy;
    int           g;
    r = bus.req; rs = rst; b = bin;
    @(posedge clk);
    cyc++;
    e_ack = '0; e_valid = 0; g = -1;
    if (rs) begin
      m_ptr = 0; m_free = 0; m_bend = 0; m_pend = 0;
      m_last_out = '0; m_last_id = 0;
    end else begin
      if (m_pend && cyc == m_due) begin
        e_valid = 1; m_last_out = m_val; m_last_id = m_id; m_pend = 0;
      end
      if (cyc >= m_free && r != '0) begin
        for (int o = 0; o < N; o++) begin
          int p;
          p = (m_ptr + o) % N;
          if (g < 0 && r[p]) g = p;
        end
        e_ack[g] = 1'b1;
        m_pend = 1; m_due = cyc + SETTLE;
        m_val  = to_bcd(int'(b[g])); m_id = g;
        m_ptr  = (g + 1) % N;
        m_free = cyc + SETTLE + 2;
        m_bend = cyc + SETTLE + 1;
      end
    end
    e_busy = !rs && (cyc < m_bend);
    #1;
    chk("ack", 32'(bus.ack), 32'(e_ack));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("bcd_valid", 32'(bus.bcd_valid), 32'(e_valid));
    chk("bcd_out", 32'(bus.bcd_out), m_last_out);
    chk("bcd_id", 32'(bus.bcd_id), 32'(m_last_id));
    for (int k = 0; k < N; k++) if (bus.ack[k]) ack_log.push_back(k);
    if (bus.bcd_valid) begin
      valid_cyc.push_back(cyc);
      out_log.push_back(32'(bus.bcd_out));
      id_log.push_back(int'(bus.bcd_id));
    end
  endtask

  task automatic clear_logs();
    ack_log.delete(); valid_cyc.delete(); id_log.delete(); out_log.delete();
  endtask

  // One isolated conversion on requester k, with literal expected BCD.
  task automatic conv(input int k, input int unsigned val, input logic [31:0] exp, input string tag);
    int n;
    bin[k] = W'(val);
    bus.req = '0;
    bus.req[k] = 1'b1;
    n = 0;
    do begin step(); n++; end while (bus.ack == '0 && n < 12);
    chk({tag, "_ack"}, 32'(bus.ack), 32'(4'b0001 << k));
    bus.req = '0;
    n = 0;
    do begin step(); n++; end while (!bus.bcd_valid && n < 12);
    chk({tag, "_latency"}, 32'(n), 32'd2);
    chk({tag, "_out"}, 32'(bus.bcd_out), exp);
    chk({tag, "_id"}, 32'(bus.bcd_id), 32'(k));
    step();
    chk({tag, "_pulse"}, 32'(bus.bcd_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req = 4'b1111;
    for (int k = 0; k < N; k++) bin[k] = W'(k * 1000 + k);
    repeat (3) step();

    // All requesters continuously: grant order from reset is 0,1,2,3,0.
    clear_logs();
    rst = 1'b0;
    step();
    chk("first_ack", 32'(bus.ack), 32'h1);
    repeat (19) step();
    chk("rr_grants", 32'(ack_log.size() >= 5), 32'd1);
    chk("rr_valids", 32'(valid_cyc.size() >= 5), 32'd1);
    if (ack_log.size() >= 5 && valid_cyc.size() >= 5) begin
      chk("rr_g0", 32'(ack_log[0]), 32'd0);
      chk("rr_g1", 32'(ack_log[1]), 32'd1);
      chk("rr_g2", 32'(ack_log[2]), 32'd2);
      chk("rr_g3", 32'(ack_log[3]), 32'd3);
      chk("rr_g4", 32'(ack_log[4]), 32'd0);
      chk("rr_id3", 32'(id_log[3]), 32'd3);
      chk("rr_id4", 32'(id_log[4]), 32'd0);
      chk("rr_o0", out_log[0], 32'h00000);
      chk("rr_o1", out_log[1], 32'h01001);
      chk("rr_o2", out_log[2], 32'h02002);
      chk("rr_o3", out_log[3], 32'h03003);
      for (int i = 1; i < 5; i++)
        chk("rr_spacing", 32'(valid_cyc[i] - valid_cyc[i-1]), 32'd4);
    end
    bus.req = '0;
    repeat (4) step();

    // Isolated conversions and boundary operands.
    rst = 1'b1; step(); rst = 1'b0;
    conv(0, 1234,  32'h01234, "c1234");
    conv(1, 0,     32'h00000, "c0");
    conv(2, 9,     32'h00009, "c9");
    conv(3, 10,    32'h00010, "c10");
    conv(0, 9999,  32'h09999, "c9999");
    conv(1, 16383, 32'h16383, "c16383");

    // Pointer after a grant to 1 is 2: req=1010 grants 3 then 1.
    rst = 1'b1; step(); rst = 1'b0;
    conv(1, 55, 32'h00055, "p1");
    clear_logs();
    bus.req = 4'b1010;
    for (int n = 0; n < 20 && ack_log.size() < 2; n++) step();
    chk("ptr_grants", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() >= 2) begin
      chk("ptr_g0", 32'(ack_log[0]), 32'd3);
      chk("ptr_g1", 32'(ack_log[1]), 32'd1);
    end
    bus.req = '0;
    repeat (5) step();

    // Reset during SETTLE discards the in-flight result.
    bin[0] = W'(777);
    bus.req = 4'b0001;
    for (int n = 0; n < 12; n++) begin
      step();
      if (bus.ack != '0) break;
    end
    chk("mid_ack", 32'(bus.ack), 32'h1);
    bus.req = '0;
    clear_logs();
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_busy", 32'(bus.busy), 32'd0);
    repeat (5) step();
    chk("mid_novalid", 32'(valid_cyc.size()), 32'd0);
    chk("mid_out", 32'(bus.bcd_out), 32'h0);
    conv(2, 42, 32'h00042, "after_rst");

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) bus.req = '0;
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 7))
          0:       bin[k] = '0;
          1:       bin[k] = '1;
          default: bin[k] = W'($urandom_range(0, 16383));
        endcase
      end
      step();
    end
    rst = 1'b0;
    bus.req = '0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
